fetch_issue_ctrl: RTL

//  Upstream neighbour of the fetch receive stage. Owns the PC and drives instruction-memory read requests.

---
 rtl/fetch_issue_ctrl_pkg.sv | 6 +
 rtl/fetch_pc_mux.sv | 21 ++
 rtl/fetch_issue_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/fetch_issue_ctrl_pkg.sv
// fetch_issue_ctrl_pkg: shared fetch FSM encodings and constants.
package fetch_issue_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2} state_t;
   localparam int unsigned PC_INCR = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_pc_mux.sv
// fetch_pc_mux: combinational next-PC select (reset > start > redirect > increment > hold).
module fetch_pc_mux
   import fetch_issue_ctrl_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS = 32,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0
) (
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic                    i_redirect,
   input  logic                    i_inc,
   input  logic [ADDRESS_BITS-1:0] i_pc,
   input  logic [ADDRESS_BITS-1:0] i_program_address,
   input  logic [ADDRESS_BITS-1:0] i_redirect_pc,
   output logic [ADDRESS_BITS-1:0] o_next_pc
);
   always_comb o_next_pc = i_reset    ? RESET_PC :
                           i_start    ? i_program_address :
                           i_redirect ? i_redirect_pc :
                           i_inc      ? i_pc + ADDRESS_BITS'(PC_INCR) : i_pc;
endmodule

// File: rtl/fetch_issue_ctrl.sv
// fetch_issue_ctrl: owns the PC, issues instruction-memory reads, drives issue_PC/flush to the receive stage.
// FETCH_MISALIGN_CHECK_EN adds misalign_exception and sends misaligned redirects back to IDLE.
module fetch_issue_ctrl
   import fetch_issue_ctrl_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS = 32,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0,
   parameter int unsigned SCAN_CYCLES_MIN = 0,
   parameter int unsigned SCAN_CYCLES_MAX = 1000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESS_BITS-1:0] program_address,
   input  logic                    stall,
   input  logic                    redirect_valid,
   input  logic [ADDRESS_BITS-1:0] redirect_PC,
   input  logic                    i_mem_ready,
   output logic                    i_mem_read,
   output logic [ADDRESS_BITS-1:0] i_mem_address,
   output logic [ADDRESS_BITS-1:0] issue_PC,
   output logic                    flush,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic                    misalign_exception,
`endif
   input  logic                    scan
);
   state_t                  r_state;
   logic [ADDRESS_BITS-1:0] r_pc, r_issue_pc, w_next_pc;
   logic                    r_flush, w_idle, w_start, w_redirect, w_accept, w_bad_target, w_unused_scan;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic r_misalign;
   assign w_bad_target       = |redirect_PC[1:0];
   assign misalign_exception = r_misalign;
`else
   assign w_bad_target = 1'b0;
`endif
   // scan tracing is a simulation-only aid; nothing in hardware consumes it
   assign w_unused_scan = scan & (SCAN_CYCLES_MIN <= SCAN_CYCLES_MAX);
   assign w_idle        = r_state == IDLE;
   assign w_start       = w_idle & start;
   assign w_redirect    = ~w_idle & redirect_valid & ~w_bad_target;
   assign w_accept      = i_mem_read & i_mem_ready & ~stall & ~redirect_valid;
   assign i_mem_read    = ~w_idle;
   assign i_mem_address = r_pc;
   assign issue_PC      = r_issue_pc;
   assign flush         = r_flush;
   fetch_pc_mux #(.ADDRESS_BITS(ADDRESS_BITS), .RESET_PC(RESET_PC)) u_pc_mux (
      .i_reset          (reset),
      .i_start          (w_start),
      .i_redirect       (w_redirect),
      .i_inc            (w_accept),
      .i_pc             (r_pc),
      .i_program_address(program_address),
      .i_redirect_pc    (redirect_PC),
      .o_next_pc        (w_next_pc)
   );
   always_ff @(posedge clock) begin
      r_pc <= w_next_pc;
      if (reset) begin
         r_state    <= IDLE;
         r_issue_pc <= RESET_PC;
         r_flush    <= 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
         r_misalign <= 1'b0;
`endif
      end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
         r_misalign <= ~w_idle & redirect_valid & w_bad_target;
`endif
         if (w_idle) begin
            r_flush <= 1'b1;
            if (start) r_state <= RUN;
         end else if (redirect_valid) begin
            r_flush <= 1'b1;
            r_state <= w_bad_target ? IDLE : RUN;
         end else if (!stall) begin
            r_flush <= ~i_mem_ready;
            r_state <= i_mem_ready ? RUN : WAIT;
            if (i_mem_ready) r_issue_pc <= r_pc;
         end
      end
   end
endmodule
